// File: rtl/tick_div_pkg.sv
// rtl/tick_div_pkg.sv - shared types and constants for the programmable tick divider
package tick_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tick_state_t;

    localparam int TD_N_CH  = 4;
    localparam int TD_WIDTH = 26;
    localparam logic [TD_WIDTH-1:0] TD_DEFAULT_LOAD = 26'd49_999_999;

    // A single channel still needs a one-bit index so the write port never collapses to zero width
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TD_CH_IDX_W = idx_width(TD_N_CH);

    typedef logic [TD_WIDTH-1:0] tick_cnt_t;

endpackage

// File: rtl/prog_tick_divider_if.sv
// rtl/prog_tick_divider_if.sv - control, load-write and tick-output bundle of the tick divider
interface prog_tick_divider_if
    import tick_div_pkg::*;
#(
    parameter int N_CH  = TD_N_CH,
    parameter int WIDTH = TD_WIDTH
);
    localparam int CH_IDX_W = idx_width(N_CH);

    logic                Enable;
    logic [N_CH-1:0]     ch_en;
    logic [N_CH-1:0]     oneshot;
    logic                wr_en;
    logic [CH_IDX_W-1:0] wr_ch;
    logic [WIDTH-1:0]    wr_data;
    logic [N_CH-1:0]     start;
    logic [N_CH-1:0]     stop;
    logic [N_CH-1:0]     tick;
    logic [N_CH-1:0]     busy;
    logic [N_CH-1:0]     done;
    logic [N_CH-1:0]     sq_o;

    modport master (
        output Enable, ch_en, oneshot, wr_en, wr_ch, wr_data, start, stop,
        input  tick, busy, done, sq_o
    );

    modport slave (
        input  Enable, ch_en, oneshot, wr_en, wr_ch, wr_data, start, stop,
        output tick, busy, done, sq_o
    );

endinterface

// File: rtl/tick_div_channel.sv
// rtl/tick_div_channel.sv - one down-counter channel with IDLE/RUN/DONE control; square output under TICK_DIV_SQUARE_EN
module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int               WIDTH        = TD_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_LOAD = WIDTH'(TD_DEFAULT_LOAD)
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             sq_o
);

    tick_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic             expire;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= DEFAULT_LOAD;
            load_q  <= DEFAULT_LOAD;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    // A start in the same cycle as a write must see the freshly written value, so it reads load_d
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        mode_d  = mode_q;
        expire  = 1'b0;
        load_d  = wr_en ? wr_data : load_q;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = load_q;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = load_d;
            mode_d  = oneshot;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && count_en) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                expire = 1'b1;
                cnt_d  = load_q;
                if (mode_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
        tick_d = expire;
    end

    assign tick = tick_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

`ifdef TICK_DIV_SQUARE_EN
    logic sq_q;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            sq_q <= 1'b0;
        end else if (stop) begin
            sq_q <= 1'b0;
        end else if (expire) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq_o = sq_q;
`else
    assign sq_o = 1'b0;
`endif

endmodule

// File: rtl/prog_tick_divider.sv
// rtl/prog_tick_divider.sv - N_CH-channel programmable tick generator; TICK_DIV_SQUARE_EN adds square outputs
module prog_tick_divider
    import tick_div_pkg::*;
#(
    parameter int               N_CH         = TD_N_CH,
    parameter int               WIDTH        = TD_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_LOAD = WIDTH'(TD_DEFAULT_LOAD)
) (
    input  logic                mclk,
    input  logic                reset,
    prog_tick_divider_if.slave  bus
);

    logic [N_CH-1:0] wr_hit;
    logic [N_CH-1:0] tick_v;
    logic [N_CH-1:0] busy_v;
    logic [N_CH-1:0] done_v;
    logic [N_CH-1:0] sq_v;

    // Indices beyond the last channel match no bit and are dropped
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_div_channel #(
            .WIDTH        (WIDTH),
            .DEFAULT_LOAD (DEFAULT_LOAD)
        ) u_ch (
            .mclk     (mclk),
            .reset    (reset),
            .count_en (bus.Enable & bus.ch_en[i]),
            .oneshot  (bus.oneshot[i]),
            .start    (bus.start[i]),
            .stop     (bus.stop[i]),
            .wr_en    (wr_hit[i]),
            .wr_data  (bus.wr_data),
            .tick     (tick_v[i]),
            .busy     (busy_v[i]),
            .done     (done_v[i]),
            .sq_o     (sq_v[i])
        );
    end

    assign bus.tick = tick_v;
    assign bus.busy = busy_v;
    assign bus.done = done_v;
    assign bus.sq_o = sq_v;

endmodule
